// File: rtl/vp_cfg_sched.sv
// Frame-synchronous configuration scheduler: shadow parameter writes are applied
// atomically on the next vsync rise, with a frame counter and lost-sync watchdog.
module vp_cfg_sched #(
    parameter int                 PARAM_W     = 8,
    parameter int                 NUM_PARAMS  = 4,
    parameter int                 ADDR_W      = 2,
    parameter logic [PARAM_W-1:0] PARAM_RST   = 8'd8,
    parameter int                 TIMEOUT_CYC = 2_000_000,
    parameter int                 TO_W        = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [PARAM_W-1:0]            cfg_data,
    input  logic                          cfg_commit,
    output logic                          cfg_err,
    input  logic                          vsync_in,
    output logic [NUM_PARAMS*PARAM_W-1:0] param_out,
    output logic                          apply_pulse,
    output logic                          cfg_pending,
    output logic [15:0]                   frame_cnt,
    output logic                          sync_lost
);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    localparam logic [ADDR_W:0] NP_LIM = (ADDR_W + 1)'(NUM_PARAMS);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);

    state_t                          state_q, state_d;
    logic                            vsync_d;
    logic                            vs_rise;
    logic                            addr_ok;
    logic                            wr_fire;
    logic                            do_apply;
    logic [PARAM_W-1:0]              shadow [NUM_PARAMS];
    logic [NUM_PARAMS*PARAM_W-1:0]   param_q;
    logic [TO_W-1:0]                 wd_q;

    assign vs_rise   = vsync_in & ~vsync_d;
    assign addr_ok   = ({1'b0, cfg_addr} < NP_LIM);
    assign wr_fire   = cfg_valid & cfg_ready;
    assign param_out = param_q;

    // A commit taken in IDLE never applies on the same cycle's vsync rise.
    always_comb begin
        state_d     = state_q;
        cfg_ready   = 1'b0;
        cfg_pending = 1'b0;
        do_apply    = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_commit) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                cfg_pending = 1'b1;
                if (vs_rise || sync_lost) begin
                    do_apply = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vsync_d     <= 1'b0;
            apply_pulse <= 1'b0;
            cfg_err     <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            state_q     <= state_d;
            vsync_d     <= vsync_in;
            apply_pulse <= do_apply;
            cfg_err     <= wr_fire & ~addr_ok;
            if (vs_rise) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                shadow[i] <= PARAM_RST;
            end
            param_q <= {NUM_PARAMS{PARAM_RST}};
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (wr_fire && addr_ok && (cfg_addr == ADDR_W'(i))) begin
                    shadow[i] <= cfg_data;
                end
                if (do_apply) begin
                    param_q[i*PARAM_W +: PARAM_W] <= shadow[i];
                end
            end
        end
    end

    // sync_lost rises on the same edge the counter reaches its saturation value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            sync_lost <= 1'b0;
        end else if (vs_rise) begin
            wd_q      <= '0;
            sync_lost <= 1'b0;
        end else begin
            if (wd_q != TO_MAX) begin
                wd_q <= wd_q + 1'b1;
            end
            if (wd_q >= TO_MAX - TO_W'(1)) begin
                sync_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vp_cfg_sched.sv
// Directed bench for vp_cfg_sched: a frame-level reference model compared on every
// cycle, plus hand-computed checks at the interesting points of each scenario.
module tb_vp_cfg_sched;

    localparam int PW  = 8;
    localparam int NP  = 3;
    localparam int AW  = 2;
    localparam int TO  = 120;
    localparam int TOW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [AW-1:0]   cfg_addr;
    logic [PW-1:0]   cfg_data;
    logic            cfg_commit;
    logic            cfg_err;
    logic            vsync_in;
    logic [NP*PW-1:0] param_out;
    logic            apply_pulse;
    logic            cfg_pending;
    logic [15:0]     frame_cnt;
    logic            sync_lost;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    vp_cfg_sched #(
        .PARAM_W    (PW),
        .NUM_PARAMS (NP),
        .ADDR_W     (AW),
        .PARAM_RST  (8'd8),
        .TIMEOUT_CYC(TO),
        .TO_W       (TOW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_err    (cfg_err),
        .vsync_in   (vsync_in),
        .param_out  (param_out),
        .apply_pulse(apply_pulse),
        .cfg_pending(cfg_pending),
        .frame_cnt  (frame_cnt),
        .sync_lost  (sync_lost)
    );

    always #5 clk = ~clk;

    // Reference model: frame-level view of shadow/active settings and sync timing.
    logic [PW-1:0] m_shadow [NP];
    logic [PW-1:0] m_active [NP];
    bit            m_pending, m_apply, m_err, m_lost, m_vs_prev;
    int            m_since;
    logic [15:0]   m_frames;

    initial begin : model
        bit rise;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < NP; i++) begin
                    m_shadow[i] = 8'd8;
                    m_active[i] = 8'd8;
                end
                m_pending = 0; m_apply = 0; m_err = 0; m_lost = 0;
                m_vs_prev = 0; m_since = 0; m_frames = 16'd0;
            end else begin
                rise      = vsync_in && !m_vs_prev;
                m_vs_prev = vsync_in;
                m_apply   = 0;
                m_err     = 0;
                if (!m_pending) begin
                    if (cfg_valid) begin
                        if (int'(cfg_addr) < NP) m_shadow[cfg_addr] = cfg_data;
                        else m_err = 1;
                    end
                    if (cfg_commit) m_pending = 1;
                end else if (rise || m_lost) begin
                    for (int i = 0; i < NP; i++) m_active[i] = m_shadow[i];
                    m_apply   = 1;
                    m_pending = 0;
                end
                if (rise) begin
                    m_frames = m_frames + 16'd1;
                    m_since  = 0;
                    m_lost   = 0;
                end else begin
                    if (m_since < TO) m_since++;
                    if (m_since >= TO) m_lost = 1;
                end
            end
        end
    end

    function automatic logic [31:0] model_params();
        logic [31:0] v = '0;
        for (int i = 0; i < NP; i++) v[i*PW +: PW] = m_active[i];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                checkOutput("param_out", 32'(param_out), model_params());
                checkOutput("apply_pulse", 32'(apply_pulse), 32'(m_apply));
                checkOutput("cfg_err", 32'(cfg_err), 32'(m_err));
                checkOutput("cfg_ready", 32'(cfg_ready), 32'(!m_pending));
                checkOutput("cfg_pending", 32'(cfg_pending), 32'(m_pending));
                checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_frames));
                checkOutput("sync_lost", 32'(sync_lost), 32'(m_lost));
            end
        end
    end

    // One clock cycle with the given inputs; returns at the following falling edge.
    task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [PW-1:0] d,
                                 input logic c, input logic vs);
        cfg_valid  = v;
        cfg_addr   = a;
        cfg_data   = d;
        cfg_commit = c;
        vsync_in   = vs;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin : stimulus
        int n;
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
        vsync_in   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset param_out", 32'(param_out), 32'h080808);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("reset frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Delayed apply: write addr1, commit, rise ~100 cycles later.
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'h40, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        idleCycles(99);
        checkOutput("held before rise", 32'(param_out), 32'h080808);
        checkOutput("pending before rise", 32'(cfg_pending), 32'd1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checkOutput("applied addr1", 32'(param_out), 32'h084008);
        checkOutput("apply pulse", 32'(apply_pulse), 32'd1);
        checkOutput("frame count 2", 32'(frame_cnt), 32'd2);
        idleCycles(1);
        checkOutput("apply pulse width", 32'(apply_pulse), 32'd0);

        // Write + commit + rise together: apply waits for the next rise.
        applyStimulus(1'b1, 2'd0, 8'h11, 1'b1, 1'b1);
        checkOutput("no same-cycle apply", 32'(apply_pulse), 32'd0);
        checkOutput("armed after commit", 32'(cfg_pending), 32'd1);
        idleCycles(2);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checkOutput("applied addr0", 32'(param_out), 32'h084011);

        // Writes stall while armed and land in the IDLE cycle after the apply.
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 2'd2, 8'hAA, 1'b0, 1'b0);
        checkOutput("ready low armed", 32'(cfg_ready), 32'd0);
        applyStimulus(1'b1, 2'd2, 8'hAA, 1'b0, 1'b1);
        checkOutput("shadow unchanged", 32'(param_out), 32'h084011);
        checkOutput("ready after apply", 32'(cfg_ready), 32'd1);
        applyStimulus(1'b1, 2'd2, 8'hAA, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checkOutput("applied addr2", 32'(param_out), 32'hAA4011);

        // Out-of-range address is accepted and flagged.
        applyStimulus(1'b1, 2'd3, 8'h55, 1'b0, 1'b0);
        checkOutput("cfg_err pulse", 32'(cfg_err), 32'd1);
        idleCycles(1);
        checkOutput("cfg_err width", 32'(cfg_err), 32'd0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checkOutput("bad write dropped", 32'(param_out), 32'hAA4011);

        // Watchdog: no vsync while armed forces an apply.
        n = 0;
        applyStimulus(1'b1, 2'd0, 8'h5A, 1'b0, 1'b0); n++;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0); n++;
        while (!sync_lost && n < 300) begin
            idleCycles(1);
            n++;
        end
        checkOutput("sync_lost latency", 32'(n), 32'(TO));
        idleCycles(1);
        checkOutput("timeout apply", 32'(apply_pulse), 32'd1);
        checkOutput("timeout params", 32'(param_out), 32'hAA405A);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checkOutput("sync regained", 32'(sync_lost), 32'd0);
        checkOutput("single apply", 32'(apply_pulse), 32'd1);
        checkOutput("frame count 8", 32'(frame_cnt), 32'd8);
        idleCycles(1);

        // Asynchronous reset while armed discards commit and shadow.
        applyStimulus(1'b1, 2'd1, 8'h77, 1'b1, 1'b0);
        idleCycles(2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst params", 32'(param_out), 32'h080808);
        checkOutput("async rst pending", 32'(cfg_pending), 32'd0);
        checkOutput("async rst frame", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        checkOutput("rise after reset", 32'(frame_cnt), 32'd1);
        idleCycles(3);
        checkOutput("commit discarded", 32'(param_out), 32'h080808);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
